// File: rtl/spi_ram_ctrl.sv
// Command controller between an SPI slave's parallel rx/tx handshake and a single-port sync RAM.
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after each access.
module spi_ram_ctrl #(
  parameter int unsigned ADDR_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [ADDR_width+1:0] rx_data,
  output logic                  tx_valid,
  output logic [ADDR_width-1:0] tx_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_width-1:0] mem_addr,
  output logic [ADDR_width-1:0] mem_wdata,
  input  logic [ADDR_width-1:0] mem_rdata,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned AW = ADDR_width;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    TX      = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] wr_addr, wr_addr_nx;
  logic [AW-1:0] rd_addr, rd_addr_nx;
  logic [AW-1:0] tx_data_nx, mem_addr_nx, mem_wdata_nx;
  logic          tx_valid_nx, mem_en_nx, mem_we_nx, busy_nx, overrun_nx;
  logic [1:0]    cmd;
  logic [AW-1:0] payload;

  assign cmd     = rx_data[AW+1:AW];
  assign payload = rx_data[AW-1:0];

  // Next-state and next-output decode; RAM strobes are computed one edge early so they
  // are registered high exactly during their own state cycle.
  always_comb begin
    state_nx     = state;
    wr_addr_nx   = wr_addr;
    rd_addr_nx   = rd_addr;
    tx_valid_nx  = 1'b0;
    tx_data_nx   = tx_data;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    overrun_nx   = overrun | (rx_valid && (state != IDLE));

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (cmd)
            2'b00: wr_addr_nx = payload;
            2'b01: begin
              state_nx     = WRITE;
              mem_en_nx    = 1'b1;
              mem_we_nx    = 1'b1;
              mem_addr_nx  = wr_addr;
              mem_wdata_nx = payload;
            end
            2'b10: rd_addr_nx = payload;
            2'b11: begin
              state_nx    = RD_REQ;
              mem_en_nx   = 1'b1;
              mem_addr_nx = rd_addr;
            end
          endcase
        end
      end
      WRITE: begin
        state_nx = IDLE;
`ifdef SPI_RAM_AUTOINC_EN
        wr_addr_nx = wr_addr + AW'(1);
`endif
      end
      RD_REQ: begin
        state_nx = RD_WAIT;
`ifdef SPI_RAM_AUTOINC_EN
        rd_addr_nx = rd_addr + AW'(1);
`endif
      end
      RD_WAIT: begin
        state_nx    = TX;
        tx_data_nx  = mem_rdata;
        tx_valid_nx = 1'b1;
      end
      TX:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_addr   <= wr_addr_nx;
      rd_addr   <= rd_addr_nx;
      tx_valid  <= tx_valid_nx;
      tx_data   <= tx_data_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      busy      <= busy_nx;
      overrun   <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: RAM environment, transaction-level reference model, per-cycle compare.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [9:0] rx_data = '0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, overrun;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  spi_ram_ctrl #(.ADDR_width(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Synchronous single-port RAM seen by the DUT, preloaded with a known pattern
  logic [7:0] ram [256];
  initial begin : ram_env
    for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'h5A;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: cycle k is the interval after posedge k. Accepted commands post
  // the RAM access and the read return as events on future cycles.
  logic [7:0]  model_mem [256];
  logic [16:0] en_ev [int];   // {we, addr, wdata}
  logic [7:0]  tx_ev [int];
  bit          rst_ev [int];
  logic [7:0]  m_wr = '0, m_rd = '0;
  bit          m_over = 1'b0;
  int          busy_last = -10;

  initial begin : model
    for (int a = 0; a < 256; a++) model_mem[a] = 8'(a) ^ 8'h5A;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        m_wr = '0; m_rd = '0; m_over = 1'b0; busy_last = -10;
        rst_ev[cyc] = 1'b1;
        for (int j = cyc; j <= cyc + 4; j++) begin
          if (en_ev.exists(j)) en_ev.delete(j);
          if (tx_ev.exists(j)) tx_ev.delete(j);
        end
      end else if (rx_valid) begin
        if (cyc < busy_last + 2) m_over = 1'b1;
        else begin
          case (rx_data[9:8])
            2'b00: m_wr = rx_data[7:0];
            2'b01: begin
              en_ev[cyc] = {1'b1, m_wr, rx_data[7:0]};
              model_mem[m_wr] = rx_data[7:0];
              busy_last = cyc;
`ifdef SPI_RAM_AUTOINC_EN
              m_wr = m_wr + 8'd1;
`endif
            end
            2'b10: m_rd = rx_data[7:0];
            default: begin
              en_ev[cyc] = {1'b0, m_rd, 8'h00};
              tx_ev[cyc + 2] = model_mem[m_rd];
              busy_last = cyc + 2;
`ifdef SPI_RAM_AUTOINC_EN
              m_rd = m_rd + 8'd1;
`endif
            end
          endcase
        end
      end
    end
  end

  // Per-cycle compare of every output against the model, on the falling edge
  logic [7:0] h_addr = '0, h_wd = '0, h_tx = '0;
  initial begin : compare
    logic       e_en, e_we, e_txv;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_ev.exists(cyc)) begin h_addr = '0; h_wd = '0; h_tx = '0; end
        e_en = en_ev.exists(cyc);
        e_we = 1'b0;
        if (e_en) begin
          e_we   = en_ev[cyc][16];
          h_addr = en_ev[cyc][15:8];
          if (e_we) h_wd = en_ev[cyc][7:0];
        end
        e_txv = tx_ev.exists(cyc);
        if (e_txv) h_tx = tx_ev[cyc];
        chk("mem_en",    8'(mem_en),   8'(e_en));
        chk("mem_we",    8'(mem_we),   8'(e_we));
        chk("mem_addr",  mem_addr,     h_addr);
        chk("mem_wdata", mem_wdata,    h_wd);
        chk("tx_valid",  8'(tx_valid), 8'(e_txv));
        chk("tx_data",   tx_data,      h_tx);
        chk("busy",      8'(busy),     8'(cyc <= busy_last));
        chk("overrun",   8'(overrun),  8'(m_over));
      end
    end
  end

  // Present one word for one edge; returns 2 time units after that edge
  task automatic drive(input logic v, input logic [9:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 10'h000);
  endtask

  initial begin : stim
    rst = 1'b1;
    idle(2);
    chk("lit_reset_busy",  8'(busy),    8'h00);
    chk("lit_reset_addr",  mem_addr,    8'h00);
    rst = 1'b0;
    idle(1);

    // Set write address 0, then write 0xA5
    drive(1'b1, 10'h000);
    idle(1);
    drive(1'b1, 10'h1A5);
    chk("lit_wr_en",    8'({mem_en, mem_we}), 8'h03);
    chk("lit_wr_addr",  mem_addr,  8'h00);
    chk("lit_wr_data",  mem_wdata, 8'hA5);
    idle(1);
    chk("lit_wr_en_off", 8'(mem_en), 8'h00);
    chk("lit_wr_ovr",    8'(overrun), 8'h00);

    // Write 0x3C to 0x10, then read it back
    drive(1'b1, 10'h010);
    drive(1'b1, 10'h13C);
    idle(1);
    drive(1'b1, 10'h210);
    drive(1'b1, 10'h300);
    chk("lit_rd_en",   8'({mem_en, mem_we}), 8'h02);
    chk("lit_rd_addr", mem_addr, 8'h10);
    idle(2);
    chk("lit_rd_txv",  8'(tx_valid), 8'h01);
    chk("lit_rd_txd",  tx_data, 8'h3C);
    idle(1);
    chk("lit_rd_txv_off", 8'(tx_valid), 8'h00);
    chk("lit_rd_txd_hold", tx_data, 8'h3C);

    // Read with words arriving 1 and 3 cycles later: both dropped
    drive(1'b1, 10'h300);
    drive(1'b1, 10'h0AA);
    chk("lit_ovr_busy", 8'(busy), 8'h01);
    idle(1);
    chk("lit_ovr_txv",  8'(tx_valid), 8'h01);
    drive(1'b1, 10'h1BB);
    chk("lit_ovr_set",  8'(overrun), 8'h01);
    chk("lit_ovr_idle", 8'(busy), 8'h00);
    idle(2);

    // Reset one cycle into a read: no tx_valid, then a fresh read hits address 0
    drive(1'b1, 10'h300);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("lit_abort_ovr",  8'(overrun), 8'h00);
    chk("lit_abort_busy", 8'(busy), 8'h00);
    idle(3);
    drive(1'b1, 10'h300);
    chk("lit_rst_rd_addr", mem_addr, 8'h00);
    idle(2);
    chk("lit_rst_rd_txd", tx_data, 8'hA5);
    idle(2);

    // Write stream across the top of the address range
    drive(1'b1, 10'h0FF);
    drive(1'b1, 10'h111);
    chk("lit_wrap_a0", mem_addr, 8'hFF);
    idle(1);
    drive(1'b1, 10'h122);
`ifdef SPI_RAM_AUTOINC_EN
    chk("lit_wrap_a1", mem_addr, 8'h00);
`else
    chk("lit_wrap_a1", mem_addr, 8'hFF);
`endif
    idle(1);
    drive(1'b1, 10'h2FF);
    drive(1'b1, 10'h300);
    idle(2);
`ifdef SPI_RAM_AUTOINC_EN
    chk("lit_wrap_rd", tx_data, 8'h11);
`else
    chk("lit_wrap_rd", tx_data, 8'h22);
`endif
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command controller between the SPI slave's parallel receive/transmit handshake and a single-port synchronous RAM. It decodes each 10-bit word delivered on `rx_data` into write-address, write-data, read-address or read-request operations. It sequences the RAM port and returns read data to the SPI slave on `tx_data`/`tx_valid`. One operation is in flight at a time; words arriving while busy are dropped and flagged.

## Interface

- `ADDR_width`, 8, RAM address and data width; `rx_data` is `ADDR_width+2` bits.

- `clk`  input  1  system clock, shared with the SPI slave.
- `rst`  input  1  synchronous, active-high reset.
- `rx_valid`  input  1  one-cycle strobe from the SPI slave; `rx_data` is valid.
- `rx_data`  input  ADDR_width+2  `[ADDR_width+1:ADDR_width]` is the command, `[ADDR_width-1:0]` is the payload.
- `tx_valid`  output  1  one-cycle strobe to the SPI slave; `tx_data` is valid.
- `tx_data`  output  ADDR_width  read data returned to the SPI slave.
- `mem_en`  output  1  RAM port enable.
- `mem_we`  output  1  RAM write enable; valid only with `mem_en`.
- `mem_addr`  output  ADDR_width  RAM address.
- `mem_wdata`  output  ADDR_width  RAM write data.
- `mem_rdata`  input  ADDR_width  RAM read data, valid one cycle after a read enable.
- `busy`  output  1  high whenever the state is not IDLE.
- `overrun`  output  1  sticky; set when an `rx_valid` word is dropped.

## Operation

- All outputs are registered. Reset values are all 0: `tx_valid`, `tx_data`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `overrun`. Internal `wr_addr` and `rd_addr` reset to 0. State resets to IDLE.
- States: IDLE, WRITE, RD_REQ, RD_WAIT, TX.
- Commands are decoded only in IDLE with `rx_valid=1`:
  - `00` (set write address): `wr_addr <= payload`; stay in IDLE.
  - `01` (write data): go to WRITE. In WRITE: `mem_en=1`, `mem_we=1`, `mem_addr=wr_addr`, `mem_wdata=payload`.
  - `10` (set read address): `rd_addr <= payload`; stay in IDLE.
  - `11` (read request): payload is ignored; go to RD_REQ.
- State behaviour:
  - WRITE: goes to IDLE.
  - RD_REQ: `mem_en=1`, `mem_we=0`, `mem_addr=rd_addr`; goes to RD_WAIT.
  - RD_WAIT: captures `mem_rdata` into `tx_data`; goes to TX.
  - TX: `tx_valid=1`; goes to IDLE.
- `mem_en`/`mem_we` are high only in their state cycle. `mem_addr`/`mem_wdata` hold their last value otherwise.
- `tx_data` holds its value until the next RD_WAIT.
- `rx_valid=1` in any state other than IDLE: the word is discarded and `overrun <= 1`. Only `rst` clears `overrun`.
- Address arithmetic is modulo 2^ADDR_width; 0xFF+1 wraps to 0x00 for the default width.
- A read with no prior `10` command reads address 0.
- `rst` asserted mid-operation: the next edge forces IDLE and all reset values. An aborted read never raises `tx_valid`; an aborted write never raises `mem_we` after reset.

## Timing

- `rx_valid` is sampled at edge N; register updates appear after edge N.
- Set-address commands: the new address is usable by a command accepted at edge N+1. No busy cycle.
- Write: `mem_en`/`mem_we` high in cycle N+1. IDLE again at N+2, so back-to-back accepted words can be spaced 2 cycles apart.
- Read: `mem_en` in cycle N+1 and `mem_rdata` sampled at the end of cycle N+2. `tx_valid` is high in cycle N+3 (latency 3). IDLE again at N+4.
- `busy` is high from N+1 through the last non-IDLE cycle.
- An `rx_valid` arriving on the edge that returns the FSM to IDLE is still dropped, because the state is not yet IDLE at that edge.

## Configuration

- `SPI_RAM_AUTOINC_EN` defined: `wr_addr` increments (wrapping) after every WRITE cycle, and `rd_addr` increments (wrapping) after every RD_REQ cycle. Streams of `01` or `11` commands then walk consecutive addresses.
- Not defined: `wr_addr` and `rd_addr` change only via the `00`/`10` commands.

## Test plan

- Reset then `rx_data=0x000`, then `0x1A5` two cycles later → `mem_en=mem_we=1`, `mem_addr=0x00`, `mem_wdata=0xA5` for exactly one cycle; `overrun=0`.
- Write 0x3C to address 0x10, then `0x210`, `0x300` → `mem_en=1`, `mem_we=0`, `mem_addr=0x10` one cycle after the `0x300` strobe. Model returns 0x3C; `tx_valid=1` with `tx_data=0x3C` exactly 3 cycles after the strobe, for one cycle.
- `0x300` then `rx_valid` again 1 and 3 cycles later → both dropped, `busy=1` for 3 cycles, `overrun=1` until `rst`. The read still completes with `tx_valid` at +3.
- `rst` pulsed one cycle after `0x300` → no `tx_valid` ever; all outputs 0; the next `0x300` reads address 0.
- With `SPI_RAM_AUTOINC_EN`: `0x0FF`, `0x111`, `0x122` → writes to 0xFF then 0x00 (wrap). Without the macro, both writes go to 0xFF.
